dm_store_rmw: RTL and testbench



---
 rtl/dm_pkg.sv | 25 ++
 rtl/dm_store_merge.sv | 36 +++
 rtl/dm_store_rmw.sv | 135 +++++++++++++
 tb/tb_dm_store_rmw.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: store/load op codes, RMW FSM state encodings and the byte-lane
// mapping helper shared by the data-memory store and load-extension paths.
package dm_pkg;

    // Store op field, shared with the load-extension op encoding.
    typedef logic [1:0] st_op_t;
    localparam st_op_t ST_SW  = 2'b00;
    localparam st_op_t ST_SH  = 2'b01;
    localparam st_op_t ST_SB  = 2'b10;
    localparam st_op_t ST_RSV = 2'b11;

    // Store RMW sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10
    } dm_state_e;

    // Physical byte lane holding byte offset a within the word.
    // Little-endian: offset 0 sits in bits [7:0]; big-endian: in bits [31:24].
    function automatic logic [1:0] lane_sel(input logic [1:0] a, input logic little_end);
        return little_end ? a : ~a;
    endfunction

endpackage

// File: rtl/dm_store_merge.sv
// dm_store_merge: combinational lane merge of store data into a read word.
// sw passes the store data through, sh/sb replace one halfword/byte lane,
// the reserved op returns the read word unchanged.
module dm_store_merge
    import dm_pkg::*;
#(
    parameter bit LITTLE_END = 1'b1
) (
    input  logic [31:0] rdata_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  a_i,
    input  st_op_t      op_i,
    output logic [31:0] wdata_o
);

    logic [1:0] byte_lane;
    logic [1:0] hw_first_lane;
    logic       hw_lane;

    // Pick the target lane and splice the low byte/halfword of data into it.
    always_comb begin
        byte_lane     = lane_sel(a_i, LITTLE_END);
        // Both bytes of a halfword share one physical halfword; its index is
        // the upper bit of the lane holding the first byte.
        hw_first_lane = lane_sel({a_i[1], 1'b0}, LITTLE_END);
        hw_lane       = hw_first_lane[1];
        wdata_o       = rdata_i;
        case (op_i)
            ST_SW:   wdata_o = data_i;
            ST_SH:   wdata_o[{hw_lane, 4'b0000} +: 16] = data_i[15:0];
            ST_SB:   wdata_o[{byte_lane, 3'b000} +: 8] = data_i[7:0];
            default: wdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dm_store_rmw.sv
// dm_store_rmw: store path in front of a word-wide data memory without byte
// enables. sw writes in one busy cycle; sh/sb read the word, merge the lane
// and write it back (two busy cycles). Reserved ops are dropped with a done
// pulse. Optional macro DM_MISALIGN_TRAP_EN drops misaligned sw/sh with an
// error pulse; without it the offending low address bits are cleared.
module dm_store_rmw
    import dm_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter bit LITTLE_END = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [31:0]       st_addr_i,
    input  logic [31:0]       st_data_i,
    input  logic [1:0]        st_op_i,
    output logic              st_done_o,
    output logic              st_err_o,
    output logic              mem_busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    dm_state_e          state_q, state_d;
    logic [1:0]         a_q;
    logic [31:0]        data_q;
    st_op_t             op_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               drop_q;
    logic               accept;
    logic               trap;
    logic [1:0]         a_fix;
    logic [31:0]        merged;
    logic               unused_addr_hi;

    // Address bits above the DM size wrap away.
    assign unused_addr_hi = ^st_addr_i[31:ADDR_W+2];

    assign accept = st_valid_i && (state_q == S_IDLE);

    // Misalignment handling: trap and drop, or clear the offending bits.
    always_comb begin
`ifdef DM_MISALIGN_TRAP_EN
        trap  = ((st_op_i == ST_SW) && (st_addr_i[1:0] != 2'b00)) ||
                ((st_op_i == ST_SH) && st_addr_i[0]);
        a_fix = st_addr_i[1:0];
`else
        trap  = 1'b0;
        case (st_op_i)
            ST_SW:   a_fix = 2'b00;
            ST_SH:   a_fix = {st_addr_i[1], 1'b0};
            default: a_fix = st_addr_i[1:0];
        endcase
`endif
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state: sw skips the read, sh/sb read first, drops stay idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !trap && (st_op_i != ST_RSV))
                    state_d = (st_op_i == ST_SW) ? S_WR : S_RD;
            end
            S_RD:    state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, word address and the one-cycle drop/error flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_q        <= 2'b00;
            data_q     <= 32'h0;
            op_q       <= ST_SW;
            mem_addr_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (accept) begin
                a_q        <= a_fix;
                data_q     <= st_data_i;
                op_q       <= st_op_i;
                mem_addr_q <= st_addr_i[ADDR_W+1:2];
                drop_q     <= trap || (st_op_i == ST_RSV);
            end
        end
    end

`ifdef DM_MISALIGN_TRAP_EN
    logic err_q;

    // Error flag pulses alongside the drop pulse of a trapped request.
    always_ff @(posedge clk_i) begin
        if (reset_i) err_q <= 1'b0;
        else         err_q <= accept && trap;
    end

    assign st_err_o = err_q;
`else
    assign st_err_o = 1'b0;
`endif

    dm_store_merge #(
        .LITTLE_END (LITTLE_END)
    ) u_merge (
        .rdata_i (mem_rdata_i),
        .data_i  (data_q),
        .a_i     (a_q),
        .op_i    (op_q),
        .wdata_o (merged)
    );

    // Outputs decoded from state; write data only driven during WR.
    always_comb begin
        st_ready_o  = (state_q == S_IDLE);
        mem_busy_o  = (state_q != S_IDLE);
        mem_we_o    = (state_q == S_WR);
        st_done_o   = (state_q == S_WR) || drop_q;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = (state_q == S_WR) ? merged : 32'h0;
    end

endmodule

// File: tb/tb_dm_store_rmw.sv
// tb_dm_store_rmw: directed bench for dm_store_rmw (little-endian, ADDR_W=10)
// with a synchronous-read word memory model attached to the DM port.
module tb_dm_store_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_op;
    logic        st_done;
    logic        st_err;
    logic        mem_busy;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_store_rmw #(.ADDR_W(10), .LITTLE_END(1'b1)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .st_valid_i  (st_valid),
        .st_ready_o  (st_ready),
        .st_addr_i   (st_addr),
        .st_data_i   (st_data),
        .st_op_i     (st_op),
        .st_done_o   (st_done),
        .st_err_o    (st_err),
        .mem_busy_o  (mem_busy),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Data memory model: read-old synchronous read, bench preload port.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
        st_valid = 1'b1; st_addr = a; st_data = d; st_op = op;
    endtask

    initial begin
        int wc;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_op = 2'b00;
        tick(); tick();
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_busy",  32'(mem_busy), 32'd0);
        check("rst_we",    32'(mem_we), 32'd0);
        check("rst_done",  32'(st_done), 32'd0);
        check("rst_err",   32'(st_err), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        tick();

        // sw: one busy cycle, write + done together
        req(32'h0000_0010, 32'hDEAD_BEEF, 2'b00);
        tick();
        st_valid = 1'b0;
        check("sw_we",    32'(mem_we), 32'd1);
        check("sw_addr",  32'(mem_addr), 32'd4);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_done",  32'(st_done), 32'd1);
        check("sw_ready", 32'(st_ready), 32'd0);
        tick();
        check("sw_ready_back", 32'(st_ready), 32'd1);
        check("sw_we_off",     32'(mem_we), 32'd0);
        check("sw_mem",        mem[4], 32'hDEAD_BEEF);

        // sb into byte 2 of word 4
        preload(10'd4, 32'h1122_3344);
        req(32'h0000_0012, 32'hFFFF_FFAB, 2'b10);
        tick();
        st_valid = 1'b0;
        check("sb_rd_we",   32'(mem_we), 32'd0);
        check("sb_rd_busy", 32'(mem_busy), 32'd1);
        check("sb_rd_done", 32'(st_done), 32'd0);
        check("sb_rd_addr", 32'(mem_addr), 32'd4);
        tick();
        check("sb_wr_we",    32'(mem_we), 32'd1);
        check("sb_wr_wdata", mem_wdata, 32'h11AB_3344);
        check("sb_wr_done",  32'(st_done), 32'd1);
        tick();
        check("sb_mem", mem[4], 32'h11AB_3344);

        // sh upper half then lower half
        preload(10'd4, 32'h1122_3344);
        req(32'h0000_0012, 32'h0000_BEEF, 2'b01);
        tick(); st_valid = 1'b0; tick();
        check("sh_hi_wdata", mem_wdata, 32'hBEEF_3344);
        tick();
        req(32'h0000_0010, 32'h0000_BEEF, 2'b01);
        tick(); st_valid = 1'b0; tick();
        check("sh_lo_wdata", mem_wdata, 32'hBEEF_BEEF);
        tick();
        check("sh_mem", mem[4], 32'hBEEF_BEEF);

        // back-to-back: sb then sw held on st_valid
        preload(10'd5, 32'hAABB_CCDD);
        wc = wr_cnt;
        req(32'h0000_0015, 32'h0000_0077, 2'b10);
        tick();
        req(32'h0000_0018, 32'h1234_5678, 2'b00);
        check("b2b_rd_ready", 32'(st_ready), 32'd0);
        tick();
        check("b2b_wr_ready", 32'(st_ready), 32'd0);
        check("b2b_sb_wdata", mem_wdata, 32'hAABB_77DD);
        tick();
        check("b2b_idle_ready", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        check("b2b_sw_addr",  32'(mem_addr), 32'd6);
        check("b2b_sw_wdata", mem_wdata, 32'h1234_5678);
        tick();
        check("b2b_mem5", mem[5], 32'hAABB_77DD);
        check("b2b_mem6", mem[6], 32'h1234_5678);
        check("b2b_wrcnt", 32'(wr_cnt - wc), 32'd2);

        // reset during the RD cycle of an sb
        preload(10'd7, 32'hCAFE_F00D);
        wc = wr_cnt;
        req(32'h0000_001C, 32'h0000_0055, 2'b10);
        tick();
        st_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("rrd_we",    32'(mem_we), 32'd0);
        check("rrd_ready", 32'(st_ready), 32'd1);
        check("rrd_busy",  32'(mem_busy), 32'd0);
        reset = 1'b0;
        tick(); tick();
        check("rrd_mem",   mem[7], 32'hCAFE_F00D);
        check("rrd_wrcnt", 32'(wr_cnt - wc), 32'd0);

        // reserved op: dropped with done, no memory access
        wc = wr_cnt;
        req(32'h0000_0020, 32'h0BAD_0BAD, 2'b11);
        tick();
        st_valid = 1'b0;
        check("rsv_done",  32'(st_done), 32'd1);
        check("rsv_ready", 32'(st_ready), 32'd1);
        check("rsv_busy",  32'(mem_busy), 32'd0);
        check("rsv_err",   32'(st_err), 32'd0);
        tick();
        check("rsv_done_pulse", 32'(st_done), 32'd0);
        check("rsv_wrcnt", 32'(wr_cnt - wc), 32'd0);

        // address wrap: upper bits dropped
        req(32'hFFFF_F004, 32'h5A5A_A5A5, 2'b00);
        tick();
        st_valid = 1'b0;
        check("wrap_addr", 32'(mem_addr), 32'd1);
        tick();

        // misaligned sh at 0x13
        preload(10'd4, 32'h1122_3344);
        wc = wr_cnt;
        req(32'h0000_0013, 32'h0000_BEEF, 2'b01);
        tick();
        st_valid = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
        check("mis_err",  32'(st_err), 32'd1);
        check("mis_done", 32'(st_done), 32'd1);
        check("mis_we",   32'(mem_we), 32'd0);
        tick();
        check("mis_err_pulse", 32'(st_err), 32'd0);
        check("mis_mem", mem[4], 32'h1122_3344);
`else
        check("mis_err",  32'(st_err), 32'd0);
        check("mis_busy", 32'(mem_busy), 32'd1);
        tick();
        check("mis_wdata", mem_wdata, 32'hBEEF_3344);
        tick();
        check("mis_mem", mem[4], 32'hBEEF_3344);
        check("mis_wrcnt", 32'(wr_cnt - wc), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
